// File: rtl/resource_router_pkg.sv
// Shared types and constants for the dual-pipeline resource response router.
package resource_router_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  localparam logic OWNER_P1 = 1'b0;
  localparam logic OWNER_P2 = 1'b1;

  typedef struct packed {
    logic owner;
    logic kill;
  } tag_t;

  localparam int ERR_NO_CREDIT = 0;
  localparam int ERR_EMPTY_TAG = 1;
  localparam int ERR_BAD_GRANT = 2;

endpackage

// File: rtl/rr_fifo.sv
// First-word-fall-through synchronous FIFO with count, synchronous clear and an
// optional keyed mark port (sets MARK_BIT in entries whose KEY_BIT matches).
module rr_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int KEY_BIT  = 0,
  parameter int MARK_BIT = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic [1:0]       mark_key,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (mark_key[mem[i][KEY_BIT]]) mem[i][MARK_BIT] <= 1'b1;
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/resource_response_router.sv
// Tracks the owning pipeline of each issued shared-resource op and steers the
// in-order results back through per-pipeline buffers, dropping flushed work.
module resource_response_router
  import resource_router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              grant_1,
  input  logic              grant_2,
  input  logic              flush_1,
  input  logic              flush_2,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              issue_ready_1,
  output logic              issue_ready_2,
  output logic              rsp_valid_1,
  output logic              rsp_valid_2,
  output logic [DATA_W-1:0] rsp_data_1,
  output logic [DATA_W-1:0] rsp_data_2,
  input  logic              rsp_ready_1,
  input  logic              rsp_ready_2,
  output logic [2:0]        err
);

  localparam int CW = $clog2(DEPTH + 1);

  tag_t          tag_head, tag_push;
  logic [CW-1:0] tag_count, buf_count_1, buf_count_2, tags_live_1, tags_live_2;
  logic [CW:0]   live_1, live_2;
  logic          tag_full, tag_empty, grants_ok, credit, issue_acc, tag_pop, route_ok;
  logic          wr_1, wr_2, rd_1, rd_2, inc_1, inc_2, dec_1, dec_2;

  // Credits depend only on registered counts, so there is no path from issue inputs.
  assign tag_full      = (tag_count == CW'(DEPTH));
  assign tag_empty     = (tag_count == '0);
  assign live_1        = {1'b0, tags_live_1} + {1'b0, buf_count_1};
  assign live_2        = {1'b0, tags_live_2} + {1'b0, buf_count_2};
  assign issue_ready_1 = !tag_full && (live_1 < (CW + 1)'(DEPTH));
  assign issue_ready_2 = !tag_full && (live_2 < (CW + 1)'(DEPTH));
  assign rsp_valid_1   = (buf_count_1 != '0);
  assign rsp_valid_2   = (buf_count_2 != '0);

  always_comb begin
    grants_ok      = grant_1 ^ grant_2;
    credit         = grant_2 ? issue_ready_2 : issue_ready_1;
    issue_acc      = issue_valid && grants_ok && credit;
    tag_push.owner = grant_2;
    tag_push.kill  = grant_2 ? flush_2 : flush_1;
    tag_pop        = res_valid && !tag_empty;
    route_ok       = tag_pop && !tag_head.kill;
    // A flush in the same cycle as the result beats the result.
    wr_1           = route_ok && (tag_head.owner == OWNER_P1) && !flush_1;
    wr_2           = route_ok && (tag_head.owner == OWNER_P2) && !flush_2;
    rd_1           = rsp_valid_1 && rsp_ready_1 && !flush_1;
    rd_2           = rsp_valid_2 && rsp_ready_2 && !flush_2;
    inc_1          = issue_acc && (grant_2 == OWNER_P1);
    inc_2          = issue_acc && (grant_2 == OWNER_P2);
    dec_1          = route_ok && (tag_head.owner == OWNER_P1);
    dec_2          = route_ok && (tag_head.owner == OWNER_P2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tags_live_1 <= '0;
      tags_live_2 <= '0;
      err         <= '0;
    end else begin
      tags_live_1 <= flush_1 ? '0 : tags_live_1 + CW'(inc_1) - CW'(dec_1);
      tags_live_2 <= flush_2 ? '0 : tags_live_2 + CW'(inc_2) - CW'(dec_2);
      if (issue_valid && grants_ok && !credit) err[ERR_NO_CREDIT] <= 1'b1;
      if (res_valid && tag_empty)              err[ERR_EMPTY_TAG] <= 1'b1;
      if (issue_valid && !grants_ok)           err[ERR_BAD_GRANT] <= 1'b1;
    end
  end

  rr_fifo #(.WIDTH(2), .DEPTH(DEPTH), .KEY_BIT(1), .MARK_BIT(0)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (issue_acc),
    .push_data (tag_push),
    .pop       (tag_pop),
    .mark_key  ({flush_2, flush_1}),
    .head      (tag_head),
    .count     (tag_count)
  );

  rr_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_buf_1 (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush_1),
    .push      (wr_1),
    .push_data (res_data),
    .pop       (rd_1),
    .mark_key  (2'b00),
    .head      (rsp_data_1),
    .count     (buf_count_1)
  );

  rr_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_buf_2 (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush_2),
    .push      (wr_2),
    .push_data (res_data),
    .pop       (rd_2),
    .mark_key  (2'b00),
    .head      (rsp_data_2),
    .count     (buf_count_2)
  );

endmodule

// File: tb/tb_resource_response_router.sv
// Directed bench for resource_response_router: routing, credits, flush, errors, reset.
module tb_resource_response_router;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0, grant_1 = 1'b0, grant_2 = 1'b0;
  logic        flush_1 = 1'b0, flush_2 = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        issue_ready_1, issue_ready_2, rsp_valid_1, rsp_valid_2;
  logic [31:0] rsp_data_1, rsp_data_2;
  logic        rsp_ready_1 = 1'b0, rsp_ready_2 = 1'b0;
  logic [2:0]  err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  resource_response_router #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .grant_1(grant_1), .grant_2(grant_2), .flush_1(flush_1), .flush_2(flush_2),
    .res_valid(res_valid), .res_data(res_data),
    .issue_ready_1(issue_ready_1), .issue_ready_2(issue_ready_2),
    .rsp_valid_1(rsp_valid_1), .rsp_valid_2(rsp_valid_2),
    .rsp_data_1(rsp_data_1), .rsp_data_2(rsp_data_2),
    .rsp_ready_1(rsp_ready_1), .rsp_ready_2(rsp_ready_2), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic to_p2);
    issue_valid = 1'b1;
    grant_1     = !to_p2;
    grant_2     = to_p2;
    tick();
    issue_valid = 1'b0;
    grant_1     = 1'b0;
    grant_2     = 1'b0;
  endtask

  task automatic result(input logic [31:0] d);
    res_valid = 1'b1;
    res_data  = d;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_valid_1", 32'(rsp_valid_1), 32'd0);
    chk("rst_valid_2", 32'(rsp_valid_2), 32'd0);
    chk("rst_data_1", rsp_data_1, 32'd0);
    chk("rst_data_2", rsp_data_2, 32'd0);
    chk("rst_ready_1", 32'(issue_ready_1), 32'd1);
    chk("rst_ready_2", 32'(issue_ready_2), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // Interleaved owners, both consumers ready.
    rsp_ready_1 = 1'b1;
    rsp_ready_2 = 1'b1;
    issue(1'b0);
    issue(1'b1);
    issue(1'b0);
    result(32'hA);
    chk("route_a_valid_1", 32'(rsp_valid_1), 32'd1);
    chk("route_a_data_1", rsp_data_1, 32'hA);
    chk("route_a_valid_2", 32'(rsp_valid_2), 32'd0);
    result(32'hB);
    chk("route_b_valid_1", 32'(rsp_valid_1), 32'd0);
    chk("route_b_valid_2", 32'(rsp_valid_2), 32'd1);
    chk("route_b_data_2", rsp_data_2, 32'hB);
    result(32'hC);
    chk("route_c_valid_1", 32'(rsp_valid_1), 32'd1);
    chk("route_c_data_1", rsp_data_1, 32'hC);
    chk("route_c_valid_2", 32'(rsp_valid_2), 32'd0);
    tick();
    chk("route_drain_1", 32'(rsp_valid_1), 32'd0);
    chk("route_err", 32'(err), 32'd0);

    // Credit exhaustion on pipeline 1 with a stalled consumer.
    rsp_ready_1 = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0);
    chk("cred_full_ready_1", 32'(issue_ready_1), 32'd0);
    chk("cred_tagfull_ready_2", 32'(issue_ready_2), 32'd0);
    for (int i = 0; i < 4; i++) result(32'h10 + 32'(i));
    chk("cred_buf_ready_1", 32'(issue_ready_1), 32'd0);
    chk("cred_buf_ready_2", 32'(issue_ready_2), 32'd1);
    rsp_ready_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("cred_beat_valid", 32'(rsp_valid_1), 32'd1);
      chk("cred_beat_data", rsp_data_1, 32'h10 + 32'(i));
      tick();
    end
    chk("cred_empty_valid_1", 32'(rsp_valid_1), 32'd0);
    chk("cred_back_ready_1", 32'(issue_ready_1), 32'd1);

    // Flush pipeline 1 with both owners outstanding.
    issue(1'b0);
    issue(1'b1);
    flush_1 = 1'b1;
    tick();
    flush_1 = 1'b0;
    chk("flush_ready_1", 32'(issue_ready_1), 32'd1);
    result(32'h21);
    chk("flush_drop_valid_1", 32'(rsp_valid_1), 32'd0);
    chk("flush_drop_valid_2", 32'(rsp_valid_2), 32'd0);
    result(32'h22);
    chk("flush_keep_valid_1", 32'(rsp_valid_1), 32'd0);
    chk("flush_keep_valid_2", 32'(rsp_valid_2), 32'd1);
    chk("flush_keep_data_2", rsp_data_2, 32'h22);
    tick();
    chk("flush_err", 32'(err), 32'd0);

    // Flush beats a same-cycle rsp_ready.
    rsp_ready_2 = 1'b0;
    issue(1'b1);
    result(32'h33);
    chk("fl_rdy_valid_2", 32'(rsp_valid_2), 32'd1);
    chk("fl_rdy_data_2", rsp_data_2, 32'h33);
    flush_2     = 1'b1;
    rsp_ready_2 = 1'b1;
    tick();
    flush_2 = 1'b0;
    chk("fl_rdy_cleared_2", 32'(rsp_valid_2), 32'd0);
    chk("fl_rdy_ready_2", 32'(issue_ready_2), 32'd1);

    // Result with nothing outstanding.
    result(32'h44);
    chk("empty_res_valid_1", 32'(rsp_valid_1), 32'd0);
    chk("empty_res_valid_2", 32'(rsp_valid_2), 32'd0);
    chk("empty_res_err", 32'(err), 32'b010);
    tick();
    chk("empty_res_sticky", 32'(err), 32'b010);

    // Bad grants, then issue without credit.
    issue_valid = 1'b1;
    grant_1     = 1'b1;
    grant_2     = 1'b1;
    tick();
    issue_valid = 1'b0;
    grant_1     = 1'b0;
    grant_2     = 1'b0;
    chk("bad_grant_err", 32'(err), 32'b110);
    chk("bad_grant_ready_1", 32'(issue_ready_1), 32'd1);
    rsp_ready_1 = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0);
    chk("nocred_ready_1", 32'(issue_ready_1), 32'd0);
    issue(1'b0);
    chk("nocred_err", 32'(err), 32'b111);

    // Two results buffered, three outstanding, then reset.
    result(32'h50);
    result(32'h51);
    issue(1'b1);
    chk("pre_rst_valid_1", 32'(rsp_valid_1), 32'd1);
    chk("pre_rst_data_1", rsp_data_1, 32'h50);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid_1", 32'(rsp_valid_1), 32'd0);
    chk("mid_rst_valid_2", 32'(rsp_valid_2), 32'd0);
    chk("mid_rst_ready_1", 32'(issue_ready_1), 32'd1);
    chk("mid_rst_ready_2", 32'(issue_ready_2), 32'd1);
    chk("mid_rst_err", 32'(err), 32'd0);
    result(32'h52);
    chk("post_rst_err", 32'(err), 32'b010);
    chk("post_rst_valid_1", 32'(rsp_valid_1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/resource_response_router.md
# resource_response_router

Return-path block for the dual-pipeline shared-resource subsystem. It records which pipeline was granted each issued resource operation, steers each in-order resource result back to the owning pipeline through a per-pipeline output buffer with valid/ready handshake, and discards results belonging to flushed pipelines. It sits between the shared resource's output and the two pipeline instances, and supplies per-pipeline issue credits that the wrapper folds into each pipeline's stall.

## Interface
- DATA_W, 32, result data width
- DEPTH, 4, tag FIFO depth and per-pipeline output buffer depth (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  an operation enters the shared resource this cycle
- grant_1 / grant_2  in  1 each  arbiter grants; exactly one high when issue_valid
- flush_1 / flush_2  in  1 each  per-pipeline flush
- res_valid  in  1  shared resource presents a result (in issue order)
- res_data  in  DATA_W  result data
- issue_ready_1 / issue_ready_2  out  1 each  pipeline n may issue this cycle
- rsp_valid_1 / rsp_valid_2  out  1 each  result available to pipeline n
- rsp_data_1 / rsp_data_2  out  DATA_W each  result for pipeline n
- rsp_ready_1 / rsp_ready_2  in  1 each  pipeline n accepts result
- err  out  3  sticky: [0] issue without credit, [1] result with empty tag FIFO, [2] grant not one-hot on issue

## Operation
- Tag FIFO (DEPTH entries): each entry {owner, kill}. Accepted issue pushes {owner = grant_2, kill = flush_owner}.
- Issue accepted when issue_valid, grants one-hot, and issue_ready_owner. Otherwise issue ignored; set err[0] (no credit) or err[2] (bad grants).
- issue_ready_n = tag FIFO not full AND live_n < DEPTH, where live_n = non-killed outstanding tags of n + entries in buffer n.
- res_valid pops head tag. kill=0: write res_data into buffer owner. kill=1: drop. Empty FIFO: drop, set err[1].
- Output buffers: first-word-fall-through; rsp_valid_n = buffer n non-empty; pop on rsp_valid_n && rsp_ready_n. Credit rule guarantees no overflow.
- flush_n: clears buffer n, sets kill on every FIFO entry with owner n (including one pushed same cycle), zeroes live_n next cycle. Pipeline m≠n unaffected.
- Reset: both FIFOs and buffers empty, all counters 0, err = 0.

## Timing
- Reset values: rsp_valid_* = 0, rsp_data_* = 0, issue_ready_* = 1, err = 0.
- Result accepted at cycle N → rsp_valid_n high at N+1 (1-cycle latency) when buffer was empty.
- Issue and result in same cycle: pop uses the existing head; push lands behind; on empty FIFO the same-cycle result is unexpected (err[1]).
- Full tag FIFO with simultaneous pop: issue_ready still 0 that cycle (registered, conservative).
- Buffer n full with simultaneous pop and write: both occur, count unchanged.
- Flush and rsp_ready same cycle: flush wins; no data delivered.
- Flush and result to same pipeline same cycle: result dropped.
- issue_ready_* combinational from registered counts only (no path from issue_valid/grants).
- Reset mid-operation: all outstanding tags and buffered data discarded; err cleared.

## Structure
- Package resource_router_pkg: DATA_W/DEPTH defaults, owner encoding constants (OWNER_P1 = 0, OWNER_P2 = 1), tag struct {owner, kill}, err bit indices.
- One sub-module: rr_fifo, parameterised width/depth FWFT synchronous FIFO with count output and synchronous clear; instantiated three times (tag FIFO with per-entry kill-set port, two output buffers).
- Top holds issue qualification, live_n counters, routing, error flags.

## Test plan
- Issue p1, p2, p1; results 0xA, 0xB, 0xC; rsp_ready high → p1 gets 0xA at N+1 then 0xC, p2 gets 0xB; err = 0.
- rsp_ready_1 low, issue 4 p1 ops, return all → buffer 1 holds 4, issue_ready_1 = 0, issue_ready_2 = 1; release ready → 4 beats in order.
- Issue p1, p2 outstanding; flush_1 → both results return; only p2 result delivered; live_1 = 0, issue_ready_1 = 1.
- res_valid with empty tag FIFO → no rsp_valid, err[1] set and held until reset.
- Issue with grant_1 = grant_2 = 1 → no push, err[2] = 1; issue with issue_ready_1 = 0 → err[0] = 1.
- Reset asserted with 3 outstanding and 2 buffered → next cycle rsp_valid_* = 0, issue_ready_* = 1, err = 0; later results flag err[1].
